// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port data memory arbiter between instruction fetch and load/store unit
//
// Purpose:
//   Shares one registered-read, byte-addressed memory between instruction fetch (IF, read-only,
//   always a 32-bit word) and the load/store unit (LSU, read/write, width-coded). One access is
//   in flight at a time: IDLE -> ISSUE -> CAPT -> IDLE, or IDLE -> ERR -> IDLE for rejected
//   accesses. Each accepted request gets exactly one single-cycle ack.
//
// Configuration:
//   MEM_ARB_RR_EN  defined: round-robin between IF and LSU on contention.
//                  undefined: fixed priority, LSU always wins contention.
//
// Ports:
//   i_clk, i_rst_n                   clock (rising edge), asynchronous active-low reset
//   i_if_req, i_if_addr              fetch request and byte address (held until o_if_ack)
//   o_if_ack, o_if_rdata             fetch ack pulse and fetched word (0 if out of range)
//   i_lsu_req, i_lsu_we, i_lsu_b     LSU request, store enable, width code
//   i_lsu_addr, i_lsu_wdata          LSU byte address and store data
//   o_lsu_ack, o_lsu_rdata           LSU ack pulse and load result (0 for stores/errors)
//   o_lsu_err                        access rejected, qualified by o_lsu_ack
//   o_mem_ad, o_mem_we, o_mem_b      memory address, write enable, width code
//   o_mem_wdata, i_mem_rdata         memory write data, registered memory read data
//   o_busy                           high whenever an access is in flight

module mem_arbiter #(
  parameter int BITS      = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_if_req,
  input  logic [BITS-1:0] i_if_addr,
  output logic            o_if_ack,
  output logic [BITS-1:0] o_if_rdata,
  input  logic            i_lsu_req,
  input  logic            i_lsu_we,
  input  logic [2:0]      i_lsu_b,
  input  logic [BITS-1:0] i_lsu_addr,
  input  logic [BITS-1:0] i_lsu_wdata,
  output logic            o_lsu_ack,
  output logic [BITS-1:0] o_lsu_rdata,
  output logic            o_lsu_err,
  output logic [BITS-1:0] o_mem_ad,
  output logic            o_mem_we,
  output logic [2:0]      o_mem_b,
  output logic [BITS-1:0] o_mem_wdata,
  input  logic [BITS-1:0] i_mem_rdata,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [2:0]    LP_B_WORD  = 3'b010;
  localparam logic [BITS:0] LP_MEM_END = (BITS+1)'(MEM_BYTES);

  // Access size in bytes; the low two bits of the width code select 1/2/4/8.
  function automatic logic [3:0] f_size(input logic [2:0] b);
    case (b[1:0])
      2'b00:   f_size = 4'd1;
      2'b01:   f_size = 4'd2;
      2'b10:   f_size = 4'd4;
      default: f_size = 4'd8;
    endcase
  endfunction

  // One extra bit so addresses near the top of the address space cannot wrap into range.
  function automatic logic f_out_of_range(input logic [BITS-1:0] addr, input logic [3:0] size);
    logic [BITS:0] w_end;
    w_end = {1'b0, addr} + (BITS+1)'(size);
    f_out_of_range = (w_end > LP_MEM_END);
  endfunction

  // Registered state
  state_t          r_state;
  logic            r_win_lsu;   // winner of the access in flight
  logic            r_is_store;
  logic            r_if_ack;
  logic [BITS-1:0] r_if_rdata;
  logic            r_lsu_ack;
  logic [BITS-1:0] r_lsu_rdata;
  logic            r_lsu_err;
  logic [BITS-1:0] r_mem_ad;
  logic            r_mem_we;
  logic [2:0]      r_mem_b;
  logic [BITS-1:0] r_mem_wdata;
`ifdef MEM_ARB_RR_EN
  logic            r_last_lsu;  // 0 = IF granted last (reset value), 1 = LSU granted last
`endif

  // Next-state values
  state_t          w_state_n;
  logic            w_win_lsu_n;
  logic            w_is_store_n;
  logic            w_if_ack_n;
  logic [BITS-1:0] w_if_rdata_n;
  logic            w_lsu_ack_n;
  logic [BITS-1:0] w_lsu_rdata_n;
  logic            w_lsu_err_n;
  logic [BITS-1:0] w_mem_ad_n;
  logic            w_mem_we_n;
  logic [2:0]      w_mem_b_n;
  logic [BITS-1:0] w_mem_wdata_n;

  logic            w_pick_lsu;
  logic            w_lsu_bad_width;
  logic            w_lsu_bad;
  logic            w_if_bad;
  logic            w_accept;

  // Widths that do not exist on this data path: 111 always, D/WU only on a 64-bit path.
  assign w_lsu_bad_width = (i_lsu_b == 3'b111) ||
                           ((BITS == 32) && ((i_lsu_b == 3'b011) || (i_lsu_b == 3'b110)));
  assign w_lsu_bad       = w_lsu_bad_width || f_out_of_range(i_lsu_addr, f_size(i_lsu_b));
  assign w_if_bad        = f_out_of_range(i_if_addr, 4'd4);
  assign w_accept        = (r_state == S_IDLE) && (i_lsu_req || i_if_req);

`ifdef MEM_ARB_RR_EN
  // On contention, the requester not granted last wins; a lone requester always wins.
  assign w_pick_lsu = i_lsu_req && (!i_if_req || !r_last_lsu);
`else
  assign w_pick_lsu = i_lsu_req;
`endif

  always_comb begin
    w_state_n     = r_state;
    w_win_lsu_n   = r_win_lsu;
    w_is_store_n  = r_is_store;
    w_if_ack_n    = 1'b0;
    w_if_rdata_n  = '0;
    w_lsu_ack_n   = 1'b0;
    w_lsu_rdata_n = '0;
    w_lsu_err_n   = 1'b0;
    w_mem_ad_n    = r_mem_ad;
    w_mem_we_n    = 1'b0;       // write enable lives for the ISSUE cycle only
    w_mem_b_n     = r_mem_b;
    w_mem_wdata_n = r_mem_wdata;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_win_lsu_n = w_pick_lsu;
          if (w_pick_lsu) begin
            if (w_lsu_bad) begin
              // Rejected accesses never reach the memory pins.
              w_is_store_n = 1'b0;
              w_state_n    = S_ERR;
            end else begin
              w_mem_ad_n    = i_lsu_addr;
              w_mem_b_n     = i_lsu_b;
              w_mem_wdata_n = i_lsu_wdata;
              w_mem_we_n    = i_lsu_we;
              w_is_store_n  = i_lsu_we;
              w_state_n     = S_ISSUE;
            end
          end else begin
            w_is_store_n = 1'b0;
            if (w_if_bad) begin
              w_state_n = S_ERR;
            end else begin
              w_mem_ad_n    = i_if_addr;
              w_mem_b_n     = LP_B_WORD;
              w_mem_wdata_n = '0;
              w_state_n     = S_ISSUE;
            end
          end
        end
      end

      S_ISSUE: begin
        // Memory samples address/width/data at this edge; read data appears during CAPT.
        w_state_n = S_CAPT;
      end

      S_CAPT: begin
        if (r_win_lsu) begin
          w_lsu_ack_n   = 1'b1;
          w_lsu_rdata_n = r_is_store ? '0 : i_mem_rdata;
        end else begin
          w_if_ack_n   = 1'b1;
          w_if_rdata_n = i_mem_rdata;
        end
        w_state_n = S_IDLE;
      end

      S_ERR: begin
        // LSU sees an error flag; an out-of-range fetch just returns zero data.
        if (r_win_lsu) begin
          w_lsu_ack_n = 1'b1;
          w_lsu_err_n = 1'b1;
        end else begin
          w_if_ack_n = 1'b1;
        end
        w_state_n = S_IDLE;
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_win_lsu   <= 1'b0;
      r_is_store  <= 1'b0;
      r_if_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_lsu_ack   <= 1'b0;
      r_lsu_rdata <= '0;
      r_lsu_err   <= 1'b0;
      r_mem_ad    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_b     <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_n;
      r_win_lsu   <= w_win_lsu_n;
      r_is_store  <= w_is_store_n;
      r_if_ack    <= w_if_ack_n;
      r_if_rdata  <= w_if_rdata_n;
      r_lsu_ack   <= w_lsu_ack_n;
      r_lsu_rdata <= w_lsu_rdata_n;
      r_lsu_err   <= w_lsu_err_n;
      r_mem_ad    <= w_mem_ad_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_b     <= w_mem_b_n;
      r_mem_wdata <= w_mem_wdata_n;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_lsu <= 1'b0;
    end else if (w_accept) begin
      r_last_lsu <= w_pick_lsu;
    end
  end
`endif

  assign o_if_ack    = r_if_ack;
  assign o_if_rdata  = r_if_rdata;
  assign o_lsu_ack   = r_lsu_ack;
  assign o_lsu_rdata = r_lsu_rdata;
  assign o_lsu_err   = r_lsu_err;
  assign o_mem_ad    = r_mem_ad;
  assign o_mem_we    = r_mem_we;
  assign o_mem_b     = r_mem_b;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a byte-array memory model

module tb_mem_arbiter;

  localparam int BITS      = 32;
  localparam int MEM_BYTES = 4096;

  logic            clk;
  logic            rst_n;
  logic            if_req;
  logic [BITS-1:0] if_addr;
  logic            if_ack;
  logic [BITS-1:0] if_rdata;
  logic            lsu_req;
  logic            lsu_we;
  logic [2:0]      lsu_b;
  logic [BITS-1:0] lsu_addr;
  logic [BITS-1:0] lsu_wdata;
  logic            lsu_ack;
  logic [BITS-1:0] lsu_rdata;
  logic            lsu_err;
  logic [BITS-1:0] mem_ad;
  logic            mem_we;
  logic [2:0]      mem_b;
  logic [BITS-1:0] mem_wdata;
  logic [BITS-1:0] mem_rdata;
  logic            busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.BITS(BITS), .MEM_BYTES(MEM_BYTES)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_ack    (if_ack),
    .o_if_rdata  (if_rdata),
    .i_lsu_req   (lsu_req),
    .i_lsu_we    (lsu_we),
    .i_lsu_b     (lsu_b),
    .i_lsu_addr  (lsu_addr),
    .i_lsu_wdata (lsu_wdata),
    .o_lsu_ack   (lsu_ack),
    .o_lsu_rdata (lsu_rdata),
    .o_lsu_err   (lsu_err),
    .o_mem_ad    (mem_ad),
    .o_mem_we    (mem_we),
    .o_mem_b     (mem_b),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte array, registered read with sign/zero extension per width code.
  logic [7:0] mem [0:MEM_BYTES-1];
  logic       mem_init = 1'b0;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    byte_at = (a < MEM_BYTES) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] b);
    logic [7:0]  b0;
    logic [15:0] h;
    logic [31:0] w;
    b0 = byte_at(a);
    h  = {byte_at(a + 1), b0};
    w  = {byte_at(a + 3), byte_at(a + 2), h};
    case (b)
      3'b000:  mem_read = {{24{b0[7]}}, b0};
      3'b001:  mem_read = {{16{h[15]}}, h};
      3'b100:  mem_read = {24'h0, b0};
      3'b101:  mem_read = {16'h0, h};
      default: mem_read = w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
      mem[32'h100] <= 8'hEF;
      mem[32'h101] <= 8'hBE;
      mem[32'h102] <= 8'hAD;
      mem[32'h103] <= 8'hDE;
      mem_init <= 1'b1;
    end else if (mem_we && (mem_ad < MEM_BYTES - 3)) begin
      case (mem_b[1:0])
        2'b00: mem[mem_ad] <= mem_wdata[7:0];
        2'b01: begin
          mem[mem_ad]     <= mem_wdata[7:0];
          mem[mem_ad + 1] <= mem_wdata[15:8];
        end
        default: begin
          mem[mem_ad]     <= mem_wdata[7:0];
          mem[mem_ad + 1] <= mem_wdata[15:8];
          mem[mem_ad + 2] <= mem_wdata[23:16];
          mem[mem_ad + 3] <= mem_wdata[31:24];
        end
      endcase
    end
    mem_rdata <= mem_read(mem_ad, mem_b);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Presents one LSU request before an edge and waits for its ack (bounded).
  task automatic lsu_access(input logic we, input logic [2:0] b, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int edges, output bit got,
                            output bit we_seen);
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = we; lsu_b = b; lsu_addr = addr; lsu_wdata = wdata;
    edges = 0; got = 0; we_seen = 0; rdata = '0; err = 1'b0;
    while (!got && edges < 10) begin
      @(posedge clk); #1;
      edges++;
      if (mem_we) we_seen = 1;
      if (lsu_ack) begin
        got = 1; rdata = lsu_rdata; err = lsu_err;
      end
    end
    lsu_req = 1'b0;
  endtask

  task automatic if_access(input logic [31:0] addr, output logic [31:0] rdata,
                           output int edges, output bit got);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    edges = 0; got = 0; rdata = '0;
    while (!got && edges < 10) begin
      @(posedge clk); #1;
      edges++;
      if (if_ack) begin
        got = 1; rdata = if_rdata;
      end
    end
    if_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  b;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          ed;
    bit          got;
    bit          wes;
    bit          got_l, got_i, first_is_lsu, any_first, ack_l_extra;
    logic [31:0] rd_l, rd_i;

    //              we    b       addr        wdata         err   rdata
    vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 3'b000, 32'h200, 32'hFFFFFF80, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 3'b000, 32'h200, 32'h0,        1'b0, 32'hFFFFFF80};
    vecs[3]  = '{1'b0, 3'b100, 32'h200, 32'h0,        1'b0, 32'h00000080};
    vecs[4]  = '{1'b0, 3'b010, 32'h200, 32'h0,        1'b0, 32'h00000080};
    vecs[5]  = '{1'b0, 3'b010, 32'hFFE, 32'h0,        1'b1, 32'h0};
    vecs[6]  = '{1'b1, 3'b111, 32'h100, 32'h11223344, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h100, 32'h0,        1'b0, 32'hFFFFBEEF};
    vecs[8]  = '{1'b0, 3'b101, 32'h100, 32'h0,        1'b0, 32'h0000BEEF};
    vecs[9]  = '{1'b0, 3'b011, 32'h100, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b0, 3'b110, 32'h100, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 3'b010, 32'h200, 32'h0,        1'b0, 32'hABCD0080};
    vecs[13] = '{1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 3'b010, 32'hFFC, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[15] = '{1'b0, 3'b000, 32'hFFF, 32'h0,        1'b0, 32'hFFFFFFCA};
    vecs[16] = '{1'b0, 3'b001, 32'hFFF, 32'h0,        1'b1, 32'h0};

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_b = '0; lsu_addr = '0; lsu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_zero",
          64'(|{if_ack, if_rdata, lsu_ack, lsu_rdata, lsu_err,
                mem_ad, mem_we, mem_b, mem_wdata, busy}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch of the preloaded word.
    if_access(32'h100, rd, ed, got);
    check("if_fetch_ack", 64'(got), 64'h1);
    check("if_fetch_data", 64'(rd), 64'hDEADBEEF);
    check("if_fetch_latency", 64'(ed), 64'd3);

    // Fetch that would run past the end of memory.
    if_access(32'hFFE, rd, ed, got);
    check("if_oor_ack", 64'(got), 64'h1);
    check("if_oor_data", 64'(rd), 64'h0);
    check("if_oor_latency", 64'(ed), 64'd2);

    // Table-driven LSU sequence.
    for (int i = 0; i < 17; i++) begin
      lsu_access(vecs[i].we, vecs[i].b, vecs[i].addr, vecs[i].wdata, rd, er, ed, got, wes);
      check($sformatf("vec%0d_ack", i), 64'(got), 64'h1);
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_latency", i), 64'(ed), vecs[i].exp_err ? 64'd2 : 64'd3);
      check($sformatf("vec%0d_mem_we", i), 64'(wes), 64'(vecs[i].we && !vecs[i].exp_err));
      @(posedge clk); #1;
      check($sformatf("vec%0d_single_ack", i), 64'(lsu_ack), 64'h0);
    end
    check("err_store_mem_unchanged", 64'(mem_read(32'h100, 3'b010)), 64'hDEADBEEF);
    check("sb_neighbour_byte", 64'(mem_read(32'h201, 3'b100)), 64'h0);

    // Contention: both request in the same cycle. Last accepted access was the LSU.
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_b = 3'b010; lsu_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h200;
    got_l = 0; got_i = 0; any_first = 0; first_is_lsu = 0; ack_l_extra = 0;
    rd_l = '0; rd_i = '0;
    for (int c = 0; c < 20 && !(got_l && got_i); c++) begin
      @(posedge clk); #1;
      if (lsu_ack) begin
        if (got_l) ack_l_extra = 1;
        if (!any_first) begin any_first = 1; first_is_lsu = 1; end
        got_l = 1; rd_l = lsu_rdata; lsu_req = 1'b0;
      end
      if (if_ack) begin
        if (!any_first) begin any_first = 1; first_is_lsu = 0; end
        got_i = 1; rd_i = if_rdata; if_req = 1'b0;
      end
    end
    lsu_req = 1'b0; if_req = 1'b0;
    check("contend_lsu_acked", 64'(got_l), 64'h1);
    check("contend_if_acked", 64'(got_i), 64'h1);
`ifdef MEM_ARB_RR_EN
    check("contend_first_is_lsu", 64'(first_is_lsu), 64'h0);
`else
    check("contend_first_is_lsu", 64'(first_is_lsu), 64'h1);
`endif
    check("contend_lsu_data", 64'(rd_l), 64'hDEADBEEF);
    check("contend_if_data", 64'(rd_i), 64'hABCD0080);
    check("contend_single_lsu_ack", 64'(ack_l_extra), 64'h0);

    // Reset asserted while a store is in ISSUE: nothing commits, no ack.
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_b = 3'b010; lsu_addr = 32'h300; lsu_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    check("rst_issue_we_high", 64'(mem_we), 64'h1);
    check("rst_issue_busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    lsu_req = 1'b0;
    check("rst_mid_issue_outputs_zero",
          64'(|{if_ack, if_rdata, lsu_ack, lsu_rdata, lsu_err,
                mem_ad, mem_we, mem_b, mem_wdata, busy}), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (lsu_ack || busy) got = 1;
    end
    check("rst_no_ack_idle", 64'(got), 64'h0);
    check("rst_store_not_committed", 64'(mem_read(32'h300, 3'b010)), 64'h0);

    // Arbiter still works after the reset.
    lsu_access(1'b0, 3'b001, 32'h100, 32'h0, rd, er, ed, got, wes);
    check("post_rst_lh_data", 64'(rd), 64'hFFFFBEEF);
    check("post_rst_lh_latency", 64'(ed), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
